// File: rtl/det_sched.sv
// det_sched: round-robin scheduler that time-shares one serial sequence
// detector among N_REQ requesters. The winner's word is latched, the detector
// is cleared, the word is shifted in MSB-first, and the detector codes are
// accumulated. The final code and match count go back to the winner with a
// one-cycle done strobe.
// Build option: define DET_SCHED_FIXED_PRIO_EN for fixed-priority
// arbitration (lowest index wins) instead of round-robin.

module det_sched #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 8,
   parameter int CNT_W  = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   output logic                      busy,
   output logic [$clog2(N_REQ)-1:0]  gnt_id,
   output logic                      done,
   output logic [2:0]                res_code,
   output logic [CNT_W-1:0]          res_cnt,
   output logic                      det_xe,
   output logic                      det_rst,
   input  logic [2:0]                det_ye
);

   localparam int ID_W  = $clog2(N_REQ);
   localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CLEAR,
      S_SHIFT,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t             state;
   logic [DATA_W-1:0]  shreg;
   logic [BIT_W-1:0]   bit_cnt;
   logic [2:0]         acc_code;
   logic [CNT_W-1:0]   acc_cnt;

   logic               win_any;
   logic [ID_W-1:0]    win_idx;
   logic [DATA_W-1:0]  win_word;
   logic [2:0]         samp_code;
   logic [CNT_W-1:0]   samp_cnt;

`ifndef DET_SCHED_FIXED_PRIO_EN
   // Last granted requester; the search starts just after it.
   logic [ID_W-1:0]    rr_ptr;
`endif

   // Arbitration: pick the requester that wins if the FSM is idle this cycle.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      win_any = 1'b0;
      win_idx = '0;
`ifdef DET_SCHED_FIXED_PRIO_EN
      for (int j = N_REQ - 1; j >= 0; j--) begin
         if (req[j]) begin
            win_any = 1'b1;
            win_idx = ID_W'(j);
         end
      end
`else
      begin
         int best_d;
         int d;
         best_d = N_REQ;
         d      = 0;
         for (int j = 0; j < N_REQ; j++) begin
            // Distance from rr_ptr+1, wrapping; smallest distance has priority.
            d = j - int'(rr_ptr) - 1;
            if (d < 0) d = d + N_REQ;
            if (req[j] && (d < best_d)) begin
               best_d  = d;
               win_any = 1'b1;
               win_idx = ID_W'(j);
            end
         end
      end
`endif
   end

   // Word of the arbitration winner.
   always_comb begin
      win_word = '0;
      for (int j = 0; j < N_REQ; j++) begin
         if (win_idx == ID_W'(j)) win_word = req_data[j*DATA_W +: DATA_W];
      end
   end

   // Accumulator values after folding in the current detector sample.
   always_comb begin
      samp_code = acc_code;
      samp_cnt  = acc_cnt;
      if (det_ye != 3'b000) begin
         samp_code = det_ye;
         if (acc_cnt != {CNT_W{1'b1}}) samp_cnt = acc_cnt + 1'b1;
      end
   end

   // Transaction FSM; every output is a register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         gnt_id   <= '0;
         res_code <= '0;
         res_cnt  <= '0;
         det_xe   <= 1'b0;
         det_rst  <= 1'b1;
         shreg    <= '0;
         bit_cnt  <= '0;
         acc_code <= '0;
         acc_cnt  <= '0;
`ifndef DET_SCHED_FIXED_PRIO_EN
         rr_ptr   <= ID_W'(N_REQ - 1);
`endif
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               det_rst <= 1'b1;
               det_xe  <= 1'b0;
               if (win_any) begin
                  shreg    <= win_word;
                  gnt_id   <= win_idx;
`ifndef DET_SCHED_FIXED_PRIO_EN
                  rr_ptr   <= win_idx;
`endif
                  acc_code <= '0;
                  acc_cnt  <= '0;
                  busy     <= 1'b1;
                  state    <= S_CLEAR;
               end
            end
            S_CLEAR: begin
               // Detector has seen one clear cycle; present the first bit.
               det_rst <= 1'b0;
               det_xe  <= shreg[DATA_W-1];
               shreg   <= shreg << 1;
               bit_cnt <= '0;
               state   <= S_SHIFT;
            end
            S_SHIFT: begin
               // At bit_cnt==0 the detector output still reflects the clear.
               if (bit_cnt != '0) begin
                  acc_code <= samp_code;
                  acc_cnt  <= samp_cnt;
               end
               if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                  det_xe <= 1'b0;
                  state  <= S_DRAIN;
               end else begin
                  det_xe  <= shreg[DATA_W-1];
                  shreg   <= shreg << 1;
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end
            S_DRAIN: begin
               // Code for the last bit arrives now; publish the result.
               acc_code <= samp_code;
               acc_cnt  <= samp_cnt;
               res_code <= samp_code;
               res_cnt  <= samp_cnt;
               done     <= 1'b1;
               det_rst  <= 1'b1;
               state    <= S_DONE;
            end
            S_DONE: begin
               det_rst <= 1'b1;
               busy    <= 1'b0;
               state   <= S_IDLE;
            end
            default: begin
               busy    <= 1'b0;
               det_rst <= 1'b1;
               det_xe  <= 1'b0;
               state   <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_det_sched.sv
// Directed testbench for det_sched. Contains a behavioural model of the
// serial sequence detector: patterns 101 -> 001, 1001 -> 010,
// 100001 -> 111; the pattern history restarts after each match.

module tb_det_sched;

   localparam int N_REQ  = 4;
   localparam int DATA_W = 8;
   localparam int CNT_W  = 4;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [N_REQ-1:0]         req;
   logic [N_REQ*DATA_W-1:0]  req_data;
   logic                     busy;
   logic [1:0]               gnt_id;
   logic                     done;
   logic [2:0]               res_code;
   logic [CNT_W-1:0]         res_cnt;
   logic                     det_xe;
   logic                     det_rst;
   logic [2:0]               det_ye;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   det_sched #(.N_REQ(N_REQ), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .req(req), .req_data(req_data),
      .busy(busy), .gnt_id(gnt_id), .done(done),
      .res_code(res_code), .res_cnt(res_cnt),
      .det_xe(det_xe), .det_rst(det_rst), .det_ye(det_ye)
   );

   // Detector model: Moore output, code valid the cycle after the bit.
   logic [5:0] hist;
   always @(posedge clk) begin
      logic [5:0] nh;
      nh = {hist[4:0], det_xe};
      if (det_rst) begin
         hist   <= '0;
         det_ye <= 3'b000;
      end else if (nh == 6'b100001) begin
         hist <= '0; det_ye <= 3'b111;
      end else if (nh[3:0] == 4'b1001) begin
         hist <= '0; det_ye <= 3'b010;
      end else if (nh[2:0] == 3'b101) begin
         hist <= '0; det_ye <= 3'b001;
      end else begin
         hist <= nh; det_ye <= 3'b000;
      end
   end

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      req = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Waits for idle, raises req, waits for done, then drops req.
   task automatic run_txn(input logic [N_REQ-1:0] r, output int cycles, output bit seen,
                          output logic [1:0] g, output logic [2:0] c, output logic [CNT_W-1:0] n);
      int guard;
      guard  = 0;
      cycles = 0;
      seen   = 1'b0;
      g = 'x; c = 'x; n = 'x;
      @(negedge clk);
      while (busy && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      req = r;
      while (!seen && cycles < 40) begin
         @(posedge clk); #1;
         cycles++;
         if (done) begin
            seen = 1'b1;
            g = gnt_id; c = res_code; n = res_cnt;
         end
      end
      req = '0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1; req = '0; req_data = '0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
      total++; if (det_rst !== 1'b1) $display("FAIL reset_det_rst got %b want 1", det_rst); else passed++;
      total++; if (gnt_id !== 2'd0) $display("FAIL reset_gnt got %0d want 0", gnt_id); else passed++;
      total++; if (res_code !== 3'd0) $display("FAIL reset_code got %0d want 0", res_code); else passed++;
      total++; if (res_cnt !== 4'd0) $display("FAIL reset_cnt got %0d want 0", res_cnt); else passed++;
      total++; if (det_xe !== 1'b0) $display("FAIL reset_xe got %b want 0", det_xe); else passed++;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         total++;
         if (done !== 1'b0 || busy !== 1'b0 || det_rst !== 1'b1)
            $display("FAIL idle_quiet cyc %0d got done=%b busy=%b det_rst=%b want 0 0 1", k, done, busy, det_rst);
         else passed++;
      end
   endtask

   task automatic test_single();
      int cyc; bit seen; logic [1:0] g; logic [2:0] c; logic [CNT_W-1:0] n;
      req_data[0 +: 8] = 8'b1010_0000;
      run_txn(4'b0001, cyc, seen, g, c, n);
      total++; if (!seen || cyc != 11) $display("FAIL single_latency got %0d seen=%b want 11", cyc, seen); else passed++;
      total++; if (g !== 2'd0) $display("FAIL single_gnt got %0d want 0", g); else passed++;
      total++; if (c !== 3'b001) $display("FAIL single_code got %b want 001", c); else passed++;
      total++; if (n !== 4'd1) $display("FAIL single_cnt got %0d want 1", n); else passed++;
   endtask

   task automatic test_codes();
      int cyc; bit seen; logic [1:0] g; logic [2:0] c; logic [CNT_W-1:0] n;
      logic [N_REQ-1:0] rv [4]  = '{4'b0010, 4'b0010, 4'b0001, 4'b0001};
      int               slot[4] = '{1, 1, 0, 0};
      logic [7:0]       wd  [4] = '{8'b1000_0100, 8'b1001_0000, 8'b1011_0101, 8'h00};
      logic [1:0]       eg  [4] = '{2'd1, 2'd1, 2'd0, 2'd0};
      logic [2:0]       ec  [4] = '{3'b111, 3'b010, 3'b001, 3'b000};
      logic [CNT_W-1:0] en  [4] = '{4'd1, 4'd1, 4'd2, 4'd0};
      for (int t = 0; t < 4; t++) begin
         req_data[slot[t]*DATA_W +: DATA_W] = wd[t];
         run_txn(rv[t], cyc, seen, g, c, n);
         total++; if (!seen) $display("FAIL codes_done vec %0d got no done want done", t); else passed++;
         total++; if (g !== eg[t]) $display("FAIL codes_gnt vec %0d got %0d want %0d", t, g, eg[t]); else passed++;
         total++; if (c !== ec[t]) $display("FAIL codes_code vec %0d got %b want %b", t, c, ec[t]); else passed++;
         total++; if (n !== en[t]) $display("FAIL codes_cnt vec %0d got %0d want %0d", t, n, en[t]); else passed++;
      end
   endtask

   task automatic test_drop();
      int cyc; bit seen;
      cyc = 0; seen = 1'b0;
      req_data[3*DATA_W +: DATA_W] = 8'b1000_0100;
      @(negedge clk);
      req = 4'b1000;
      repeat (3) @(posedge clk);
      #1; req = '0;
      while (!seen && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (done) seen = 1'b1;
      end
      total++; if (!seen) $display("FAIL drop_done got no done want done"); else passed++;
      total++; if (gnt_id !== 2'd3) $display("FAIL drop_gnt got %0d want 3", gnt_id); else passed++;
      total++; if (res_code !== 3'b111) $display("FAIL drop_code got %b want 111", res_code); else passed++;
   endtask

   task automatic test_round_robin();
      int cyc; bit seen;
`ifdef DET_SCHED_FIXED_PRIO_EN
      logic [1:0] eg[5] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`else
      logic [1:0] eg[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
`endif
      apply_reset();
      for (int i = 0; i < N_REQ; i++) req_data[i*DATA_W +: DATA_W] = 8'b1010_0000;
      req = 4'b1111;
      cyc = 0;
      for (int k = 0; k < 5; k++) begin
         seen = 1'b0;
         while (!seen && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (done) seen = 1'b1;
         end
         total++;
         if (!seen || cyc != ((k == 0) ? 11 : 12))
            $display("FAIL rr_spacing txn %0d got %0d seen=%b want %0d", k, cyc, seen, (k == 0) ? 11 : 12);
         else passed++;
         total++; if (gnt_id !== eg[k]) $display("FAIL rr_gnt txn %0d got %0d want %0d", k, gnt_id, eg[k]); else passed++;
         cyc = 0;
      end
      #1; req = '0;
   endtask

   task automatic test_abort();
      int cyc; bit seen; logic [1:0] g; logic [2:0] c; logic [CNT_W-1:0] n;
      apply_reset();
      req_data[2*DATA_W +: DATA_W] = 8'hFF;
      req = 4'b0100;
      repeat (4) @(posedge clk);
      #1;
      total++; if (busy !== 1'b1 || gnt_id !== 2'd2) $display("FAIL abort_pre got busy=%b gnt=%0d want 1 2", busy, gnt_id); else passed++;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      total++; if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy); else passed++;
      total++; if (done !== 1'b0) $display("FAIL abort_done got %b want 0", done); else passed++;
      total++; if (gnt_id !== 2'd0) $display("FAIL abort_gnt got %0d want 0", gnt_id); else passed++;
      total++; if (det_rst !== 1'b1) $display("FAIL abort_det_rst got %b want 1", det_rst); else passed++;
      total++; if (res_code !== 3'd0 || res_cnt !== 4'd0) $display("FAIL abort_res got %b/%0d want 000/0", res_code, res_cnt); else passed++;
      req = '0;
      @(negedge clk);
      rst = 1'b0;
      req_data[0 +: DATA_W]        = 8'b1010_0000;
      req_data[2*DATA_W +: DATA_W] = 8'b1011_0101;
      run_txn(4'b0101, cyc, seen, g, c, n);
      total++; if (!seen || cyc != 11) $display("FAIL abort_restart_latency got %0d seen=%b want 11", cyc, seen); else passed++;
      total++; if (g !== 2'd0) $display("FAIL abort_restart_gnt got %0d want 0", g); else passed++;
      total++; if (c !== 3'b001 || n !== 4'd1) $display("FAIL abort_restart_res got %b/%0d want 001/1", c, n); else passed++;
   endtask

   initial begin
      rst = 1'b1;
      req = '0;
      req_data = '0;
      test_reset();
      test_single();
      test_codes();
      test_drop();
      test_round_robin();
      test_abort();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
